// File: rtl/lockin_boxcar_averager_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nice_avg_pkg : shared widths, sample/accumulator types, length clamp  (rev 1.0)
// ---------------------------------------------------------------------------
package nice_avg_pkg;
  localparam int SAMPLE_W   = 24;
  localparam int MAX_LOG2_N = 12;
  localparam int FILL_W     = MAX_LOG2_N + 1;
  localparam int ACC_W      = SAMPLE_W + MAX_LOG2_N;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic [3:0]                 log2n_t;
  typedef logic [FILL_W-1:0]          fill_t;

  function automatic log2n_t clamp_log2n(input log2n_t v);
    return (int'(v) > MAX_LOG2_N) ? log2n_t'(MAX_LOG2_N) : v;
  endfunction
endpackage
`default_nettype wire

// File: rtl/lockin_boxcar_averager_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lockin_boxcar_averager_if : sample stream in, averaged readout out  (rev 1.0)
// ---------------------------------------------------------------------------
interface lockin_boxcar_averager_if #(parameter int NUM_CH = 6);
  import nice_avg_pkg::*;

  logic                   tick_i;
  sample_t [NUM_CH-1:0]   data_i;
  log2n_t                 log2n_i;
  logic                   clear_i;
  sample_t [NUM_CH-1:0]   data_o;
  logic                   done_o;
  logic [31:0]            blocks_o;
  fill_t                  fill_o;

  modport master (output tick_i, data_i, log2n_i, clear_i,
                  input  data_o, done_o, blocks_o, fill_o);
  modport slave  (input  tick_i, data_i, log2n_i, clear_i,
                  output data_o, done_o, blocks_o, fill_o);
endinterface
`default_nettype wire

// File: rtl/lockin_boxcar_averager_channel_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boxcar_channel_acc : one channel's running sum, final shift and held average  (rev 1.0)
// ---------------------------------------------------------------------------
module boxcar_channel_acc
  import nice_avg_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    tick,
  input  logic    last,
  input  logic    clear,
  input  log2n_t  len,
  input  sample_t sample,
  output sample_t avg
);
  acc_t acc;
  acc_t sum;

  assign sum = acc + acc_t'(sample);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      avg <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (tick) begin
      if (last) begin
        // Arithmetic shift floors toward -inf, matching a true floor average.
        avg <= sample_t'(sum >>> len);
        acc <= '0;
      end else begin
        acc <= sum;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/lockin_boxcar_averager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lockin_boxcar_averager : NUM_CH boxcar average + decimate by 2^L  (rev 1.0)
// ---------------------------------------------------------------------------
module lockin_boxcar_averager
  import nice_avg_pkg::*;
#(
  parameter int NUM_CH = 6
)
(
  input  logic                     clk,
  input  logic                     reset,
  lockin_boxcar_averager_if.slave  bus
);
  log2n_t               active_len;
  fill_t                fill_cnt;
  fill_t                fill_last;
  logic                 done_pulse;
  logic [31:0]          block_cnt;
  logic                 last;
  sample_t [NUM_CH-1:0] avg;

  assign fill_last = (fill_t'(1) << active_len) - fill_t'(1);
  assign last      = bus.tick_i && !bus.clear_i && (fill_cnt == fill_last);

  // The block length only reloads at a boundary so a block is never split.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_len <= clamp_log2n(bus.log2n_i);
      fill_cnt   <= '0;
      done_pulse <= 1'b0;
      block_cnt  <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (bus.clear_i) begin
        fill_cnt   <= '0;
        active_len <= clamp_log2n(bus.log2n_i);
      end else if (bus.tick_i) begin
        if (last) begin
          fill_cnt   <= '0;
          done_pulse <= 1'b1;
          block_cnt  <= block_cnt + 32'd1;
          active_len <= clamp_log2n(bus.log2n_i);
        end else begin
          fill_cnt <= fill_cnt + fill_t'(1);
        end
      end
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      boxcar_channel_acc u_acc (
        .clk    (clk),
        .reset  (reset),
        .tick   (bus.tick_i),
        .last   (last),
        .clear  (bus.clear_i),
        .len    (active_len),
        .sample (bus.data_i[c]),
        .avg    (avg[c])
      );
    end
  endgenerate

  assign bus.data_o   = avg;
  assign bus.done_o   = done_pulse;
  assign bus.blocks_o = block_cnt;
  assign bus.fill_o   = fill_cnt;
endmodule
`default_nettype wire

// File: tb/tb_lockin_boxcar_averager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lockin_boxcar_averager : vector table, directed corners, random vs. model  (rev 1.0)
// ---------------------------------------------------------------------------
module tb_lockin_boxcar_averager;
  import nice_avg_pkg::*;

  localparam int NUM_CH = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lockin_boxcar_averager_if #(.NUM_CH(NUM_CH)) bus ();
  lockin_boxcar_averager #(.NUM_CH(NUM_CH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  sample_t [NUM_CH-1:0] din;

  // Reference model: block sums as plain integers, average by floor division.
  int          m_len;
  int          m_fill;
  logic [31:0] m_blocks;
  bit          m_done;
  longint      m_sum  [NUM_CH];
  int          m_data [NUM_CH];

  typedef struct {
    bit tick;
    int v0;
    int v1;
    bit e_done;
    int e_fill;
    int e_blocks;
    int e_d0;
    int e_d1;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic int clampn(int n);
    return (n > MAX_LOG2_N) ? MAX_LOG2_N : n;
  endfunction

  function automatic void model_step(bit r, bit t, bit c, int n);
    m_done = 1'b0;
    if (r) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin m_sum[ch] = 0; m_data[ch] = 0; end
      m_fill = 0; m_blocks = 0; m_len = clampn(n);
    end else if (c) begin
      for (int ch = 0; ch < NUM_CH; ch++) m_sum[ch] = 0;
      m_fill = 0; m_len = clampn(n);
    end else if (t) begin
      for (int ch = 0; ch < NUM_CH; ch++) m_sum[ch] += longint'(din[ch]);
      m_fill++;
      if (m_fill == (1 << m_len)) begin
        longint blk = longint'(1) << m_len;
        for (int ch = 0; ch < NUM_CH; ch++) begin
          longint q = m_sum[ch] / blk;
          if ((m_sum[ch] % blk) != 0 && m_sum[ch] < 0) q = q - 1;
          m_data[ch] = int'(q);
          m_sum[ch]  = 0;
        end
        m_fill = 0; m_blocks = m_blocks + 1; m_done = 1'b1; m_len = clampn(n);
      end
    end
  endfunction

  task automatic cyc(bit r, bit t, bit c, int n);
    reset       = r;
    bus.tick_i  = t;
    bus.clear_i = c;
    bus.log2n_i = 4'(n);
    bus.data_i  = din;
    @(posedge clk);
    model_step(r, t, c, n);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".done"},   longint'(bus.done_o),   longint'(m_done));
    chk({tag, ".fill"},   longint'(bus.fill_o),   longint'(m_fill));
    chk({tag, ".blocks"}, longint'(bus.blocks_o), longint'(m_blocks));
    for (int ch = 0; ch < NUM_CH; ch++)
      chk($sformatf("%s.data%0d", tag, ch), longint'($signed(bus.data_o[ch])), longint'(m_data[ch]));
  endtask

  task automatic run(bit t, bit c, int n, string tag);
    cyc(1'b0, t, c, n);
    check_model(tag);
  endtask

  task automatic set_all(int v);
    for (int ch = 0; ch < NUM_CH; ch++) din[ch] = sample_t'(v);
  endtask

  function automatic void push(bit t, int v0, int v1, bit ed, int ef, int eb, int ed0, int ed1);
    vec_t v;
    v.tick = t; v.v0 = v0; v.v1 = v1; v.e_done = ed; v.e_fill = ef;
    v.e_blocks = eb; v.e_d0 = ed0; v.e_d1 = ed1;
    tbl.push_back(v);
  endfunction

  initial begin : main
    int t2_in0 [4];
    int t2_in1 [4];
    int done_at [$];
    int k;
    t2_in0 = '{-3, -2, -1, 0};
    t2_in1 = '{1, 1, 1, 2};

    // Test 1: four spaced ticks of 1000; Test 2: floor rounding of negative sum.
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 1000, 1000, i == 3, (i + 1) % 4, (i == 3) ? 1 : 0,
           (i == 3) ? 1000 : 0, (i == 3) ? 1000 : 0);
      for (int j = 0; j < 4; j++)
        push(1'b0, 0, 0, 1'b0, (i + 1) % 4, (i == 3) ? 1 : 0,
             (i == 3) ? 1000 : 0, (i == 3) ? 1000 : 0);
    end
    for (int i = 0; i < 4; i++)
      push(1'b1, t2_in0[i], t2_in1[i], i == 3, (i + 1) % 4, (i == 3) ? 2 : 1,
           (i == 3) ? -2 : 1000, (i == 3) ? 1 : 1000);
    push(1'b0, 0, 0, 1'b0, 0, 2, -2, 1);

    din = '0;
    cyc(1'b1, 1'b0, 1'b0, 2);
    cyc(1'b1, 1'b0, 1'b0, 2);
    chk("reset.done",   longint'(bus.done_o),   0);
    chk("reset.fill",   longint'(bus.fill_o),   0);
    chk("reset.blocks", longint'(bus.blocks_o), 0);
    chk("reset.data0",  longint'($signed(bus.data_o[0])), 0);

    foreach (tbl[i]) begin
      din[0] = sample_t'(tbl[i].v0);
      for (int ch = 1; ch < NUM_CH; ch++) din[ch] = sample_t'(tbl[i].v1);
      cyc(1'b0, tbl[i].tick, 1'b0, 2);
      chk($sformatf("tbl%0d.done", i),   longint'(bus.done_o),   longint'(tbl[i].e_done));
      chk($sformatf("tbl%0d.fill", i),   longint'(bus.fill_o),   longint'(tbl[i].e_fill));
      chk($sformatf("tbl%0d.blocks", i), longint'(bus.blocks_o), longint'(tbl[i].e_blocks));
      chk($sformatf("tbl%0d.data0", i),  longint'($signed(bus.data_o[0])), longint'(tbl[i].e_d0));
      chk($sformatf("tbl%0d.data1", i),  longint'($signed(bus.data_o[1])), longint'(tbl[i].e_d1));
    end

    // Test 3: full-scale extremes at L=4, back-to-back ticks.
    run(1'b0, 1'b1, 4, "t3.clr");
    done_at.delete();
    for (int i = 1; i <= 32; i++) begin
      set_all((i <= 16) ? -8388608 : 8388607);
      run(1'b1, 1'b0, 4, "t3");
      if (bus.done_o) done_at.push_back(i);
      if (i == 16) chk("t3.min", longint'($signed(bus.data_o[3])), -8388608);
    end
    chk("t3.max", longint'($signed(bus.data_o[5])), 8388607);
    chk("t3.blocks", longint'(bus.blocks_o), 4);
    chk("t3.ndone", done_at.size(), 2);
    if (done_at.size() == 2) chk("t3.spacing", done_at[1] - done_at[0], 16);

    // Test 4: length change mid-block waits for the boundary; then clamp to 4096.
    run(1'b0, 1'b1, 2, "t4.clr");
    done_at.delete();
    for (int i = 1; i <= 12; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) din[ch] = sample_t'($urandom);
      run(1'b1, 1'b0, (i <= 2) ? 2 : 3, "t4");
      if (bus.done_o) done_at.push_back(i);
    end
    chk("t4.ndone", done_at.size(), 2);
    if (done_at.size() == 2) begin
      chk("t4.first", done_at[0], 4);
      chk("t4.second", done_at[1], 12);
    end
    run(1'b0, 1'b1, 15, "t4.clr15");
    done_at.delete();
    for (int i = 1; i <= 4096; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) din[ch] = sample_t'($urandom);
      run(1'b1, 1'b0, 15, "t4.long");
      if (bus.done_o) done_at.push_back(i);
    end
    chk("t4.long.ndone", done_at.size(), 1);
    if (done_at.size() == 1) chk("t4.long.at", done_at[0], 4096);

    // Test 5: reset in mid-block discards the partial sum.
    run(1'b0, 1'b1, 2, "t5.clr");
    set_all(500);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 2, "t5.pre");
    cyc(1'b1, 1'b0, 1'b0, 2);
    check_model("t5.rst");
    chk("t5.rst.data0",  longint'($signed(bus.data_o[0])), 0);
    chk("t5.rst.blocks", longint'(bus.blocks_o), 0);
    chk("t5.rst.done",   longint'(bus.done_o), 0);
    for (int i = 0; i < 4; i++) run(1'b1, 1'b0, 2, "t5.post");
    chk("t5.done", longint'(bus.done_o), 1);
    chk("t5.data0", longint'($signed(bus.data_o[0])), 500);

    // Test 6: clear beats a coincident tick and produces no done.
    set_all(700);
    for (int i = 0; i < 2; i++) run(1'b1, 1'b0, 2, "t6.pre");
    set_all(99999);
    run(1'b1, 1'b1, 2, "t6.clr");
    chk("t6.fill",   longint'(bus.fill_o), 0);
    chk("t6.blocks", longint'(bus.blocks_o), 1);
    chk("t6.data0",  longint'($signed(bus.data_o[0])), 500);
    chk("t6.done",   longint'(bus.done_o), 0);
    set_all(700);
    k = 0;
    for (int i = 1; i <= 4; i++) begin
      run(1'b1, 1'b0, 2, "t6.post");
      if (bus.done_o) k = i;
    end
    chk("t6.done_at", k, 4);
    chk("t6.avg", longint'($signed(bus.data_o[2])), 700);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, t, c;
      int n;
      for (int ch = 0; ch < NUM_CH; ch++) din[ch] = sample_t'($urandom);
      t = ($urandom % 3) != 0;
      c = ($urandom % 40) == 0;
      r = ($urandom % 700) == 0;
      n = (($urandom % 8) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(0, 3));
      cyc(r, t, c, n);
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
